// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the round-robin multiplier arbiter.
// The optional watchdog in mult_arbiter is built with MULT_ARB_TIMEOUT_EN.
package mult_arb_pkg;

  localparam int DEF_N = 8;
  localparam int DEF_R = 4;
  localparam int MAX_R = 32;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY,
    DONE
  } state_t;

  // Scan downwards so the closest requester after `last` wins.
  function automatic int rr_next(
    input logic [MAX_R-1:0] req,
    input int               last,
    input int               n = DEF_R
  );
    int idx;
    rr_next = last;
    for (int i = MAX_R; i >= 1; i--) begin
      idx = (last + i) % n;
      if (i <= n && req[idx[4:0]]) rr_next = idx;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: search starts one past `last`.
// Produces a one-hot grant and the matching index.
module rr_arbiter import mult_arb_pkg::*; #(
  parameter  int R   = DEF_R,
  localparam int IDW = $clog2(R)
) (
  input  logic [R-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [R-1:0]   grant,
  output logic [IDW-1:0] grant_idx
);

  logic [MAX_R-1:0] req_ext;
  int               idx;

  assign req_ext = MAX_R'(req);

  always_comb begin
    idx              = rr_next(req_ext, int'(last), R);
    grant_idx        = IDW'(idx);
    grant            = '0;
    grant[grant_idx] = |req;
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one sequential multiplier among R requesters, round-robin.
// Define MULT_ARB_TIMEOUT_EN to add the BUSY watchdog and err pulse.
module mult_arbiter import mult_arb_pkg::*; #(
  parameter  int N       = DEF_N,
  parameter  int R       = DEF_R,
  parameter  int TIMEOUT = 2 * N + 4,
  localparam int IDW     = $clog2(R)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [R-1:0]     req,
  input  logic [R*N-1:0]   req_a,
  input  logic [R*N-1:0]   req_b,
  output logic             resp_valid,
  output logic [IDW-1:0]   resp_id,
  output logic [2*N-1:0]   resp_product,
  output logic             busy,
  output logic             err,
  output logic             mult_start,
  output logic [N-1:0]     mult_a,
  output logic [N-1:0]     mult_b,
  input  logic [2*N-1:0]   mult_product,
  input  logic             mult_ready
);

  state_t         state_q;
  state_t         state_d;
  logic [IDW-1:0] cur_id;
  logic [IDW-1:0] last;
  logic [R-1:0]   grant;
  logic [IDW-1:0] grant_idx;
  logic [2*N-1:0] prod_q;
  logic           tmo;
  logic           take;

  rr_arbiter #(
    .R(R)
  ) u_rr (
    .req      (req),
    .last     (last),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic          err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == LAUNCH) cnt <= '0;
      else if (state_q == BUSY) cnt <= cnt + CW'(1);
      if (state_q == BUSY) err_q <= tmo;
    end
  end

  // Fires on the BUSY edge that would make the count reach TIMEOUT.
  assign tmo = (state_q == BUSY) && !mult_ready &&
               (cnt == CW'(TIMEOUT - 1));
  assign err = (state_q == DONE) && err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  assign take = (state_q == BUSY) && (mult_ready || tmo);

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == IDLE:   if (|grant) state_d = LAUNCH;
      state_q == LAUNCH: state_d = BUSY;
      state_q == BUSY:   if (mult_ready || tmo) state_d = DONE;
      state_q == DONE:   state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cur_id  <= '0;
      last    <= IDW'(R - 1);
      mult_a  <= '0;
      mult_b  <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |grant) begin
        cur_id <= grant_idx;
        last   <= grant_idx;
        mult_a <= req_a[grant_idx * N +: N];
        mult_b <= req_b[grant_idx * N +: N];
      end
      if (take) prod_q <= tmo ? '0 : mult_product;
    end
  end

  assign busy         = state_q != IDLE;
  assign mult_start   = state_q == LAUNCH;
  assign resp_valid   = state_q == DONE;
  assign resp_id      = cur_id;
  assign resp_product = prod_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a behavioural multiplier.
// A cycle-level reference model is compared every falling edge.
module tb_mult_arbiter;

  localparam int N       = 8;
  localparam int R       = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 2 * N + 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [R-1:0]     req;
  logic [R*N-1:0]   req_a;
  logic [R*N-1:0]   req_b;
  logic             resp_valid;
  logic [IDW-1:0]   resp_id;
  logic [2*N-1:0]   resp_product;
  logic             busy;
  logic             err;
  logic             mult_start;
  logic [N-1:0]     mult_a;
  logic [N-1:0]     mult_b;
  logic [2*N-1:0]   mult_product;
  logic             mult_ready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int id;
    int prod;
    bit e;
    int at;
  } resp_t;

  resp_t        rlog[$];
  logic [N-1:0] qa[R][$];
  logic [N-1:0] qb[R][$];
  int           pushed[R];
  bit           stall = 1'b0;

  always #5 clock = ~clock;

  mult_arbiter #(
    .N(N),
    .R(R),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_product(resp_product),
    .busy        (busy),
    .err         (err),
    .mult_start  (mult_start),
    .mult_a      (mult_a),
    .mult_b      (mult_b),
    .mult_product(mult_product),
    .mult_ready  (mult_ready)
  );

  // Stand-in multiplier: ready N cycles after start, held until next start.
  int mcnt;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mult_ready   <= 1'b0;
      mult_product <= '0;
      mcnt         <= 0;
    end else if (mult_start) begin
      mult_ready <= 1'b0;
      mcnt       <= N;
    end else if (mcnt > 1) begin
      mcnt <= mcnt - 1;
    end else if (mcnt == 1 && !stall) begin
      mcnt         <= 0;
      mult_ready   <= 1'b1;
      mult_product <= mult_a * mult_b;
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < R; i++) begin
      req[i] = qa[i].size() != 0;
      req_a[i*N +: N] = (qa[i].size() != 0) ? qa[i][0] : '0;
      req_b[i*N +: N] = (qb[i].size() != 0) ? qb[i][0] : '0;
    end
  endtask

  // Reference model: k counts edges since the grant (0 = idle).
  int           k     = 0;
  int           mlast = R - 1;
  int           mcur  = 0;
  logic [N-1:0] ma    = '0;
  logic [N-1:0] mb    = '0;

  function automatic int done_k();
    return stall ? TIMEOUT + 2 : N + 3;
  endfunction

  function automatic int rr_pick(input logic [R-1:0] r, input int lst);
    for (int i = 1; i <= R; i++)
      if (r[(lst + i) % R]) return (lst + i) % R;
    return -1;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      k     = 0;
      mlast = R - 1;
      mcur  = 0;
      ma    = '0;
      mb    = '0;
    end else if (k == 0) begin
      if (req != '0) begin
        mcur  = rr_pick(req, mlast);
        mlast = mcur;
        ma    = qa[mcur][0];
        mb    = qb[mcur][0];
        k     = 1;
      end
    end else if (k == done_k()) begin
      k = 0;
    end else begin
      k++;
    end
  end

  always @(negedge clock) begin
    logic [2*N-1:0] ep;
    cyc++;
    if (reset) begin
      chk("busy", busy, k != 0);
      chk("mult_start", mult_start, k == 1);
      chk("resp_valid", resp_valid, k == done_k());
      chk("err", err, (k == done_k()) && stall);
      if (k != 0) begin
        chk("mult_a", mult_a, ma);
        chk("mult_b", mult_b, mb);
      end
      if (resp_valid)
        rlog.push_back('{int'(resp_id), int'(resp_product), err, cyc});
      if (k == done_k()) begin
        ep = (2*N)'(ma) * (2*N)'(mb);
        if (stall) ep = '0;
        chk("resp_id", resp_id, mcur);
        chk("resp_product", resp_product, ep);
        void'(qa[mcur].pop_front());
        void'(qb[mcur].pop_front());
        drive();
      end
    end
  end

  task automatic push(input int r, input logic [N-1:0] a,
                      input logic [N-1:0] b);
    qa[r].push_back(a);
    qb[r].push_back(b);
    pushed[r]++;
    drive();
  endtask

  task automatic step();
    @(negedge clock);
    #2;
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < R; i++) s += qa[i].size();
    return s;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", pending(), 0);
    repeat (2) step();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_id"}, resp_id, 0);
    chk({tag, "_resp_product"}, resp_product, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_mult_start"}, mult_start, 0);
    chk({tag, "_mult_a"}, mult_a, 0);
    chk({tag, "_mult_b"}, mult_b, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int b;
    int c0;
    int n;
    int cnt[R];
    int ord2[4] = '{0, 1, 2, 3};
    int prd2[4] = '{15, 63, 65025, 0};
    int ord3[8] = '{3, 0, 1, 2, 3, 0, 1, 2};
    int ord4[3] = '{0, 2, 3};

    for (int i = 0; i < R; i++) pushed[i] = 0;
    req   = '0;
    req_a = '0;
    req_b = '0;
    repeat (3) @(negedge clock);
    #2;
    check_zero("reset");
    reset = 1'b1;
    step();

    // All four requesting: rotation from requester 0.
    b = rlog.size();
    push(0, 3, 5);
    push(1, 7, 9);
    push(2, 255, 255);
    push(3, 0, 200);
    drain(200);
    chk("t2_count", rlog.size() - b, 4);
    for (int i = 0; i < 4; i++)
      if (rlog.size() > b + i) begin
        chk("t2_id", rlog[b+i].id, ord2[i]);
        chk("t2_prod", rlog[b+i].prod, prd2[i]);
      end

    // Single request: latency and product.
    b  = rlog.size();
    c0 = cyc;
    push(2, 12, 11);
    drain(100);
    chk("t1_count", rlog.size() - b, 1);
    if (rlog.size() > b) begin
      chk("t1_id", rlog[b].id, 2);
      chk("t1_prod", rlog[b].prod, 132);
      chk("t1_latency", rlog[b].at - c0, N + 3);
    end

    // Re-raised requester waits for the others.
    b = rlog.size();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < R; i++)
        push(i, N'(i * 20 + j + 1), N'(j * 50 + i + 3));
    drain(400);
    chk("t3_count", rlog.size() - b, 8);
    for (int i = 0; i < 8; i++)
      if (rlog.size() > b + i) chk("t3_order", rlog[b+i].id, ord3[i]);

    // Reset in BUSY aborts, then requester 0 wins.
    push(1, 9, 9);
    drain(100);
    push(2, 100, 3);
    push(3, 4, 4);
    push(0, 6, 7);
    n = 0;
    while (k != 3 && n < 50) begin
      step();
      n++;
    end
    chk("t4_reach_busy", k, 3);
    b = rlog.size();
    reset = 1'b0;
    #1;
    check_zero("abort");
    step();
    step();
    reset = 1'b1;
    drain(200);
    chk("t4_count", rlog.size() - b, 3);
    for (int i = 0; i < 3; i++)
      if (rlog.size() > b + i) chk("t4_order", rlog[b+i].id, ord4[i]);

`ifdef MULT_ARB_TIMEOUT_EN
    // Stalled multiplier: err with resp_valid after TIMEOUT BUSY cycles.
    stall = 1'b1;
    b  = rlog.size();
    c0 = cyc;
    push(1, 5, 6);
    drain(200);
    stall = 1'b0;
    chk("t5_count", rlog.size() - b, 1);
    if (rlog.size() > b) begin
      chk("t5_err", rlog[b].e, 1);
      chk("t5_prod", rlog[b].prod, 0);
      chk("t5_id", rlog[b].id, 1);
      chk("t5_latency", rlog[b].at - c0, TIMEOUT + 2);
    end
    step();
    chk("t5_idle", busy, 0);
`endif

    // Random operands over random requesters.
    for (int i = 0; i < 256; i++) begin
      push($urandom_range(0, R - 1),
           N'($urandom_range(0, 255)),
           N'($urandom_range(0, 255)));
      step();
    end
    drain(6000);

    for (int i = 0; i < R; i++) cnt[i] = 0;
    foreach (rlog[i]) cnt[rlog[i].id]++;
    for (int i = 0; i < R; i++) chk("answered_once", cnt[i], pushed[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin scheduler that shares one `SequentialMultiplier` (start/ready handshake, N-cycle multiply) among R requesters. It owns the multiplier's `start` and operand inputs: it picks a pending requester, launches the multiply, waits for `ready`, and returns the product tagged with the requester's ID. It sits between requester logic and a single multiplier instance, with both on the same clock and reset.

## Interface
- `N`, 8: operand width, passed to the multiplier.
- `R`, 4: number of requesters, R ≥ 2; `IDW = $clog2(R)`.
- `TIMEOUT`, 2*N+4: watchdog limit in cycles; used only with `MULT_ARB_TIMEOUT_EN`.
- `clock  in  1`: single clock; all state updates on the rising edge.
- `reset  in  1`: asynchronous, active-low; 0 resets the block immediately.
- `req  in  R`: level request per requester; held until that requester's response.
- `req_a  in  R*N`: operand A, requester i at bits [i*N +: N]; stable while `req[i]`=1.
- `req_b  in  R*N`: operand B, same packing.
- `resp_valid  out  1`: one-cycle pulse when a product is returned.
- `resp_id  out  IDW`: ID of the requester being answered; valid with `resp_valid`.
- `resp_product  out  2N`: product; valid with `resp_valid`.
- `busy  out  1`: 1 in every state except IDLE.
- `err  out  1`: one-cycle timeout pulse; constant 0 without the macro.
- `mult_start  out  1`: multiplier start.
- `mult_a  out  N`, `mult_b  out  N`: multiplier operands, registered.
- `mult_product  in  2N`, `mult_ready  in  1`: multiplier result and ready.

## Operation
- FSM states: IDLE, LAUNCH, BUSY, DONE.
- IDLE
  - If any `req` bit is 1, grant round-robin starting at `last+1` mod R.
  - On the grant: latch the granted ID into `cur_id`, latch its operands into `mult_a`/`mult_b`, set `last` = granted ID, go to LAUNCH.
  - If no `req` bit is 1, stay in IDLE.
- LAUNCH: `mult_start`=1 for exactly this cycle; go to BUSY.
- BUSY
  - `mult_start`=0.
  - Wait for `mult_ready`=1. When it is seen, register `mult_product` into `resp_product` and go to DONE.
- DONE: `resp_valid`=1 and `resp_id`=`cur_id` for one cycle; go to IDLE.
- Requesters
  - Requester `cur_id` deasserts `req` at the edge that ends its `resp_valid` cycle.
  - A `req` bit still high in the following IDLE cycle is a new request.
- Arithmetic: the multiplier is unsigned N×N→2N. The arbiter passes values through and never alters them.
- `mult_a`, `mult_b` and `cur_id` are held stable from LAUNCH through DONE.
- Requests arriving outside IDLE wait; they are arbitrated at the next IDLE cycle.
- A `req[cur_id]` drop during LAUNCH or BUSY is a protocol violation. The operation still completes and responds.
- Reset values, all outputs: 0. State returns to IDLE and `last` = R-1, so requester 0 wins first.
- Reset mid-operation aborts the operation with no response. The multiplier shares the reset.

## Timing
- `req[i]` first sampled high in IDLE at edge t. Then:
  - LAUNCH is the cycle after t, with `mult_start`=1.
  - BUSY starts at t+2.
  - DONE (`resp_valid`) comes one cycle after the BUSY cycle in which `mult_ready`=1.
- Minimum request-to-response latency for a multiplier with ready after N cycles is N+3 cycles.
- `mult_ready` is low by the first BUSY cycle, per the multiplier contract.
- Back-to-back: the next grant is decided in the IDLE cycle right after DONE, so there is one idle cycle between operations.
- Fairness: with all R requesting continuously, grants rotate 0,1,…,R-1,0. No requester waits more than R-1 operations.

## Configuration
- `MULT_ARB_TIMEOUT_EN` defined:
  - A cycle counter clears in LAUNCH and increments in BUSY.
  - If it reaches `TIMEOUT` with `mult_ready` still 0: pulse `err` for one cycle together with `resp_valid`, `resp_id`=`cur_id`, `resp_product`=0, then go to IDLE.
- Not defined: no counter; BUSY waits indefinitely; `err` is tied to 0.

## Structure
- `mult_arb_pkg` holds:
  - the `state_t` enum (IDLE, LAUNCH, BUSY, DONE);
  - the default-width localparams;
  - the function `rr_next(req, last)` returning the granted index.
- One sub-module, `rr_arbiter`: combinational round-robin grant. Inputs are `req` and `last`; outputs are a one-hot grant and its index.
- FSM, operand registers and watchdog stay in `mult_arbiter`.

## Test plan
- Reset, then only `req[2]`=1 with A=12, B=11 → `resp_valid` with `resp_id`=2 and `resp_product`=132; `mult_start` high exactly one cycle.
- All four requesters held high with operands (3,5), (7,9), (255,255), (0,200) → responses in order 0,1,2,3 with products 15, 63, 65025, 0.
- A requester whose `req` is re-raised immediately after its response, while others wait → it is not served again until all others are served.
- Reset asserted in BUSY → all outputs 0 immediately, no `resp_valid`, and the next grant goes to requester 0.
- With `MULT_ARB_TIMEOUT_EN`, `mult_ready` forced low → `err` and `resp_valid` pulse exactly `TIMEOUT` cycles after BUSY entry, then IDLE.
- 256 random operand pairs over random requesters, with a reference model comparing each result to a*b → no mismatches, and every request answered exactly once.
